// File: rtl/cpu_io_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_io_ctrl
//
// Memory-mapped I/O and interrupt responder for the cpu6502 bus. The CPU
// presents its next-cycle address, write strobe and write data. This block
// answers with registered read data, so its read latency matches the
// synchronous memory: one cycle.
//
// The block provides:
//   - an 8-bit output port
//   - a synchronized 8-bit input port
//   - a 16-bit interval timer with reload, one-shot and auto-reload modes
//   - software interrupt bits
//
// Register window (8 bytes at BASE):
//   0 PORT  R/W  output port
//   1 PIN   R    synchronized port_in
//   2 TLO   W: reload low byte
//           R: count low byte; the read also snapshots count high byte
//   3 THI   W: reload high byte and load count
//           R: snapshotted high byte
//   4 CTRL  R/W  bit0 EN, bit1 AUTO, bit2 TIE, bit3 TNMI
//   5 STAT  R/W1C bit0 TF, bit1 SIRQ, bit2 SNMI (bit3 WDF with watchdog)
//   6 SOFT  W    bit0 sets SIRQ, bit1 sets SNMI; reads 0
//   7 ID    R    8'h65 (W kicks the watchdog when it is built in)
//
// Optional feature macro: CPU_IO_WATCHDOG_EN adds an 8-bit watchdog. The
// watchdog counts timer expiries and forces nmi when it runs out. Without
// the macro, register 7 is a read-only ID and STAT bit3 reads 0.
//
// Parameters:
//   BASE      window base address; bits [2:0] must be 0
//   PIN_SYNC  number of synchronizer flops on port_in (1..3)
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   ready         bus qualifier; accesses and the timer advance only when 1
//   address_next  CPU next-cycle address
//   write_next    CPU next-cycle write strobe
//   data_o_next   CPU next-cycle write data
//   data_i        registered read data to the CPU
//   cs            registered hit; the top level muxes data_i over memory
//   port_out      output port register
//   port_in       asynchronous input pins
//   irq           level interrupt request
//   nmi           level non-maskable interrupt request
// -----------------------------------------------------------------------------
module cpu_io_ctrl #(
  parameter logic [15:0] BASE     = 16'hbff0,
  parameter int          PIN_SYNC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [15:0] address_next,
  input  logic        write_next,
  input  logic [7:0]  data_o_next,
  output logic [7:0]  data_i,
  output logic        cs,
  output logic [7:0]  port_out,
  input  logic [7:0]  port_in,
  output logic        irq,
  output logic        nmi
);

  localparam logic [2:0] REG_PORT = 3'd0;
  localparam logic [2:0] REG_PIN  = 3'd1;
  localparam logic [2:0] REG_TLO  = 3'd2;
  localparam logic [2:0] REG_THI  = 3'd3;
  localparam logic [2:0] REG_CTRL = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;
  localparam logic [2:0] REG_SOFT = 3'd6;
  localparam logic [2:0] REG_ID   = 3'd7;

  localparam logic [7:0] ID_VALUE = 8'h65;

  // Bus decode
  logic       hit;
  logic [2:0] reg_sel;
  logic       wr_en;
  logic       rd_en;
  logic       wr_port;
  logic       wr_tlo;
  logic       wr_thi;
  logic       wr_ctrl;
  logic       wr_stat;
  logic       wr_soft;
  logic       rd_tlo;

  // Input synchronizer
  logic [7:0] pin_sync [PIN_SYNC];
  logic [7:0] pin_value;

  // Timer state
  logic [7:0]  reload_lo;
  logic [7:0]  reload_hi;
  logic [7:0]  shadow_hi;
  logic [15:0] count;
  logic        en;
  logic        auto_rl;
  logic        tie;
  logic        tnmi;
  logic        run;
  logic        expire;

  // Interrupt flags
  logic tf;
  logic sirq;
  logic snmi;
  logic irq_next;
  logic nmi_next;

  logic [7:0] rd_data;
  logic [7:0] stat_value;

`ifdef CPU_IO_WATCHDOG_EN
  logic       wr_wdt;
  logic [7:0] wd_count;
  logic       wdf;
`endif

  // Only the upper 13 address bits select the window, so any BASE with
  // nonzero low bits would silently alias onto the aligned window.
  assign hit     = ready && (address_next[15:3] == BASE[15:3]);
  assign reg_sel = address_next[2:0];
  assign wr_en   = hit && write_next;
  assign rd_en   = hit && !write_next;

  assign wr_port = wr_en && (reg_sel == REG_PORT);
  assign wr_tlo  = wr_en && (reg_sel == REG_TLO);
  assign wr_thi  = wr_en && (reg_sel == REG_THI);
  assign wr_ctrl = wr_en && (reg_sel == REG_CTRL);
  assign wr_stat = wr_en && (reg_sel == REG_STAT);
  assign wr_soft = wr_en && (reg_sel == REG_SOFT);
  assign rd_tlo  = rd_en && (reg_sel == REG_TLO);

  // The timer only ticks on ready cycles. An expiry is a ready tick that
  // finds the count already at zero.
  assign run    = en && ready;
  assign expire = run && (count == 16'd0);

  // port_in is asynchronous. It passes through a short flop chain, and
  // only the last stage is ever visible to the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIN_SYNC; i++) begin
        pin_sync[i] <= 8'h00;
      end
    end else begin
      pin_sync[0] <= port_in;
      for (int i = 1; i < PIN_SYNC; i++) begin
        pin_sync[i] <= pin_sync[i-1];
      end
    end
  end

  assign pin_value = pin_sync[PIN_SYNC-1];

`ifdef CPU_IO_WATCHDOG_EN
  assign wr_wdt     = wr_en && (reg_sel == REG_ID);
  assign stat_value = {4'b0000, wdf, snmi, sirq, tf};
`else
  assign stat_value = {5'b00000, snmi, sirq, tf};
`endif

  // Read mux, built from the register values as they stand before the edge
  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      REG_PORT: rd_data = port_out;
      REG_PIN:  rd_data = pin_value;
      REG_TLO:  rd_data = count[7:0];
      REG_THI:  rd_data = shadow_hi;
      REG_CTRL: rd_data = {4'b0000, tnmi, tie, auto_rl, en};
      REG_STAT: rd_data = stat_value;
      REG_SOFT: rd_data = 8'h00;
      REG_ID:   rd_data = ID_VALUE;
      default:  rd_data = 8'h00;
    endcase
  end

  // Bus response. cs follows every hit, reads and writes alike, so the
  // top level can steer data away from memory. data_i only changes on a
  // read hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_i <= 8'h00;
      cs     <= 1'b0;
    end else begin
      cs <= hit;
      if (rd_en) begin
        data_i <= rd_data;
      end
    end
  end

  // Output port register
  always_ff @(posedge clk) begin
    if (reset) begin
      port_out <= 8'h00;
    end else if (wr_port) begin
      port_out <= data_o_next;
    end
  end

  // Interrupt routing. The timer flag goes to exactly one of irq or nmi,
  // selected by TNMI. The watchdog flag always forces nmi.
  assign irq_next = sirq | (tf & tie & ~tnmi);
`ifdef CPU_IO_WATCHDOG_EN
  assign nmi_next = snmi | (tf & tie & tnmi) | wdf;
`else
  assign nmi_next = snmi | (tf & tie & tnmi);
`endif

  // Timer, control register, flags and registered interrupt outputs.
  // Bus writes come after the timer update in this block, so a THI load
  // or a CTRL write overrides whatever the timer would have done to count
  // or EN in the same cycle. Each flag sets with priority over its
  // write-1-to-clear, so an event that coincides with a clear is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_lo <= 8'h00;
      reload_hi <= 8'h00;
      shadow_hi <= 8'h00;
      count     <= 16'h0000;
      en        <= 1'b0;
      auto_rl   <= 1'b0;
      tie       <= 1'b0;
      tnmi      <= 1'b0;
      tf        <= 1'b0;
      sirq      <= 1'b0;
      snmi      <= 1'b0;
      irq       <= 1'b0;
      nmi       <= 1'b0;
    end else begin
      if (run) begin
        if (count != 16'd0) begin
          count <= count - 16'd1;
        end else if (auto_rl) begin
          count <= {reload_hi, reload_lo};
        end else begin
          en <= 1'b0;
        end
      end

      if (wr_tlo) begin
        reload_lo <= data_o_next;
      end

      if (wr_thi) begin
        reload_hi <= data_o_next;
        count     <= {data_o_next, reload_lo};
      end

      if (wr_ctrl) begin
        en      <= data_o_next[0];
        auto_rl <= data_o_next[1];
        tie     <= data_o_next[2];
        tnmi    <= data_o_next[3];
      end

      // Latching the high byte on a TLO read lets the CPU read a 16-bit
      // count consistently, even while the timer keeps running.
      if (rd_tlo) begin
        shadow_hi <= count[15:8];
      end

      tf   <= (tf   & ~(wr_stat & data_o_next[0])) | expire;
      sirq <= (sirq & ~(wr_stat & data_o_next[1])) | (wr_soft & data_o_next[0]);
      snmi <= (snmi & ~(wr_stat & data_o_next[2])) | (wr_soft & data_o_next[1]);

      irq <= irq_next;
      nmi <= nmi_next;
    end
  end

`ifdef CPU_IO_WATCHDOG_EN
  // Watchdog: counts timer expiries down from 0xff and stops at 0. An
  // expiry that arrives while the counter is already at 0 raises WDF.
  // A kick reloads the counter and takes priority over a coincident
  // expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= 8'hff;
      wdf      <= 1'b0;
    end else begin
      if (wr_wdt) begin
        wd_count <= 8'hff;
      end else if (expire && (wd_count != 8'h00)) begin
        wd_count <= wd_count - 8'h01;
      end
      wdf <= (wdf & ~(wr_stat & data_o_next[3])) |
             (expire && (wd_count == 8'h00) && !wr_wdt);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_io_ctrl
//
// Directed bench for cpu_io_ctrl in its default build (no watchdog). Every
// access takes one clock. Outputs are sampled 1 time unit after the edge
// that performed the access. Expected values come from hand-traced cycle
// counts around the timer reload and expiry.
// -----------------------------------------------------------------------------
module tb_cpu_io_ctrl;

  localparam logic [15:0] BASE = 16'hbff0;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [15:0] address_next;
  logic        write_next;
  logic [7:0]  data_o_next;
  logic [7:0]  data_i;
  logic        cs;
  logic [7:0]  port_out;
  logic [7:0]  port_in;
  logic        irq;
  logic        nmi;

  int errors = 0;
  int checks = 0;

  cpu_io_ctrl #(
    .BASE     (BASE),
    .PIN_SYNC (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .address_next (address_next),
    .write_next   (write_next),
    .data_o_next  (data_o_next),
    .data_i       (data_i),
    .cs           (cs),
    .port_out     (port_out),
    .port_in      (port_in),
    .irq          (irq),
    .nmi          (nmi)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle. Drives the access, waits for its edge, then parks the
  // bus on an address outside the window.
  task automatic applyStimulus(input logic [15:0] a, input logic w, input logic [7:0] d);
    address_next = a;
    write_next   = w;
    data_o_next  = d;
    @(posedge clk);
    #1;
    address_next = 16'h0000;
    write_next   = 1'b0;
    data_o_next  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic writeReg(input logic [2:0] r, input logic [7:0] d);
    applyStimulus(BASE + {13'd0, r}, 1'b1, d);
  endtask

  task automatic readReg(input string tag, input logic [2:0] r, input logic [7:0] exp);
    applyStimulus(BASE + {13'd0, r}, 1'b0, 8'h00);
    checkOutput(tag, {8'h00, data_i}, {8'h00, exp});
  endtask

  initial begin
    reset        = 1'b1;
    ready        = 1'b1;
    address_next = BASE + 16'd7;
    write_next   = 1'b0;
    data_o_next  = 8'h00;
    port_in      = 8'h00;
    $display("[TB] reset with a read held on the ID register");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs",       {15'd0, cs},  16'd0);
    checkOutput("rst_data_i",   {8'd0, data_i}, 16'd0);
    checkOutput("rst_port_out", {8'd0, port_out}, 16'd0);
    checkOutput("rst_irq",      {15'd0, irq}, 16'd0);
    checkOutput("rst_nmi",      {15'd0, nmi}, 16'd0);
    reset        = 1'b0;
    address_next = 16'h0000;

    // ID read and cs behaviour
    readReg("id_read", 3'd7, 8'h65);
    checkOutput("id_cs", {15'd0, cs}, 16'd1);
    idle(1);
    checkOutput("idle_cs",   {15'd0, cs}, 16'd0);
    checkOutput("data_hold", {8'd0, data_i}, 16'h0065);

    // Output port
    writeReg(3'd0, 8'ha5);
    checkOutput("port_out_wr", {8'd0, port_out}, 16'h00a5);
    checkOutput("wr_cs",       {15'd0, cs}, 16'd1);
    readReg("port_rd", 3'd0, 8'ha5);

    // Input synchronizer: two flops, then one cycle of read latency
    port_in = 8'h3c;
    readReg("pin_early", 3'd1, 8'h00);
    idle(1);
    readReg("pin_sync", 3'd1, 8'h3c);

    // Auto-reload timer, reload 3. TF sets on the 4th edge after CTRL (E4).
    $display("[TB] auto-reload timer");
    writeReg(3'd2, 8'h03);
    writeReg(3'd3, 8'h00);
    writeReg(3'd4, 8'h07);                              // E0
    checkOutput("irq_start", {15'd0, irq}, 16'd0);
    idle(3);                                            // E1..E3
    readReg("tf_before", 3'd5, 8'h00);                  // E4
    checkOutput("irq_e4", {15'd0, irq}, 16'd0);
    readReg("tf_set", 3'd5, 8'h01);                     // E5
    checkOutput("irq_e5", {15'd0, irq}, 16'd1);
    writeReg(3'd5, 8'h01);                              // E6 clear
    idle(1);                                            // E7
    checkOutput("irq_clr", {15'd0, irq}, 16'd0);
    idle(1);                                            // E8 expiry
    checkOutput("irq_e8", {15'd0, irq}, 16'd0);
    idle(1);                                            // E9
    checkOutput("irq_again", {15'd0, irq}, 16'd1);
    writeReg(3'd5, 8'h01);                              // E10 clear
    readReg("tf_cleared", 3'd5, 8'h00);                 // E11
    writeReg(3'd5, 8'h01);                              // E12 clear vs expiry
    readReg("set_wins", 3'd5, 8'h01);                   // E13
    writeReg(3'd4, 8'h00);                              // E14 stop
    writeReg(3'd5, 8'h01);                              // E15 clear
    idle(2);
    checkOutput("irq_off", {15'd0, irq}, 16'd0);

    // One-shot to nmi, reload 2, with a ready=0 freeze first
    $display("[TB] one-shot timer routed to nmi");
    writeReg(3'd2, 8'h02);
    writeReg(3'd3, 8'h00);
    writeReg(3'd4, 8'h0d);                              // F0
    ready        = 1'b0;
    address_next = BASE + 16'd7;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("not_ready_cs", {15'd0, cs}, 16'd0);
    ready        = 1'b1;
    address_next = 16'h0000;
    readReg("frozen", 3'd2, 8'h02);                     // G1: 2->1
    readReg("en_on", 3'd4, 8'h0d);                      // G2: 1->0
    idle(1);                                            // G3: expiry
    checkOutput("nmi_g3", {15'd0, nmi}, 16'd0);
    readReg("os_tf", 3'd5, 8'h01);                      // G4
    checkOutput("nmi_os", {15'd0, nmi}, 16'd1);
    checkOutput("irq_os", {15'd0, irq}, 16'd0);
    readReg("en_off", 3'd4, 8'h0c);
    writeReg(3'd5, 8'h01);
    idle(1);
    checkOutput("nmi_clr", {15'd0, nmi}, 16'd0);
    idle(3);
    checkOutput("nmi_once", {15'd0, nmi}, 16'd0);
    readReg("stat_quiet", 3'd5, 8'h00);

    // Count load and high-byte shadow (the timer is stopped)
    writeReg(3'd2, 8'h34);
    writeReg(3'd3, 8'h12);
    readReg("thi_old", 3'd3, 8'h00);
    readReg("tlo_rd", 3'd2, 8'h34);
    readReg("thi_rd", 3'd3, 8'h12);

    // Reserved bits and read-only registers
    writeReg(3'd4, 8'hf0);
    readReg("ctrl_hi", 3'd4, 8'h00);
    writeReg(3'd7, 8'h00);
    readReg("id_ro", 3'd7, 8'h65);
    writeReg(3'd1, 8'hff);
    readReg("pin_ro", 3'd1, 8'h3c);
    readReg("soft_rd", 3'd6, 8'h00);

    // Software interrupts
    writeReg(3'd6, 8'h01);
    checkOutput("sirq_lat", {15'd0, irq}, 16'd0);
    idle(1);
    checkOutput("sirq_irq", {15'd0, irq}, 16'd1);
    readReg("stat_sirq", 3'd5, 8'h02);
    writeReg(3'd6, 8'h02);
    idle(1);
    checkOutput("snmi_nmi", {15'd0, nmi}, 16'd1);
    writeReg(3'd5, 8'h06);
    idle(1);
    checkOutput("soft_clr_irq", {15'd0, irq}, 16'd0);
    checkOutput("soft_clr_nmi", {15'd0, nmi}, 16'd0);

    // Window edges
    applyStimulus(BASE + 16'd8, 1'b0, 8'h00);
    checkOutput("above_cs", {15'd0, cs}, 16'd0);
    applyStimulus(BASE - 16'd1, 1'b0, 8'h00);
    checkOutput("below_cs", {15'd0, cs}, 16'd0);

    // Reset in the middle of activity
    writeReg(3'd0, 8'h5a);
    writeReg(3'd6, 8'h01);
    writeReg(3'd2, 8'h00);
    writeReg(3'd3, 8'h00);
    writeReg(3'd4, 8'h07);
    idle(2);
    checkOutput("pre_rst_irq", {15'd0, irq}, 16'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_irq",  {15'd0, irq}, 16'd0);
    checkOutput("mid_rst_port", {8'd0, port_out}, 16'd0);
    reset = 1'b0;
    readReg("rst_ctrl", 3'd4, 8'h00);
    readReg("rst_stat", 3'd5, 8'h00);
    readReg("rst_tlo",  3'd2, 8'h00);
    idle(2);
    checkOutput("rst_irq_quiet", {15'd0, irq}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
